// File: rtl/vm2_qbus_pkg.sv
// Shared definitions for the Q-bus master bridge: FSM states and default bus timing.
package vm2_qbus_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAsync,
        StRdin,
        StWdat,
        StWdout,
        StRlse,
        StNrply,
        StDone,
        StIack
    } qb_state_e;

    localparam int unsigned TAsuDef = 2;
    localparam int unsigned TAhdDef = 2;
    localparam int unsigned TDsuDef = 2;
    localparam int unsigned TmoDef  = 255;

    // Addresses in the top 8 KB select the I/O page.
    function automatic logic is_bs7(input logic [15:0] adr);
        return adr[15:13] == 3'b111;
    endfunction

endpackage

// File: rtl/vm2_qbus_sync2.sv
// Two-flop synchronizer for asynchronous Q-bus inputs, cleared by the synchronous reset.
module qbus_sync2 #(
    parameter int unsigned Width = 1
) (
    input  logic             vm_clk_p,
    input  logic             vm_rst_n,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge vm_clk_p) begin
        if (!vm_rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/vm2_qbus_master.sv
// Wishbone slave to Q-bus master bridge: runs DATI/DATO/DATOB and IAK cycles with RPLY timeout.
module vm2_qbus_master
    import vm2_qbus_pkg::*;
#(
    parameter int unsigned T_ASU = TAsuDef,
    parameter int unsigned T_AHD = TAhdDef,
    parameter int unsigned T_DSU = TDsuDef,
    parameter int unsigned TMO   = TmoDef
) (
    input  logic        vm_clk_p,
    input  logic        vm_rst_n,
    input  logic [15:0] wbs_adr_i,
    input  logic [15:0] wbs_dat_i,
    output logic [15:0] wbs_dat_o,
    input  logic [1:0]  wbs_sel_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    input  logic        wbi_stb_i,
    output logic [15:0] wbi_dat_o,
    output logic        wbi_ack_o,
    output logic [15:0] qb_ad_o,
    output logic        qb_ad_oe,
    input  logic [15:0] qb_ad_i,
    output logic        qb_sync_o,
    output logic        qb_din_o,
    output logic        qb_dout_o,
    output logic        qb_wtbt_o,
    output logic        qb_bs7_o,
    output logic        qb_iako_o,
    input  logic        qb_rply_i
);

    localparam logic [7:0] AsuLast = 8'(T_ASU - 1);
    localparam logic [7:0] AhdLast = 8'(T_AHD - 1);
    localparam logic [7:0] DsuLast = 8'(T_DSU - 1);
    localparam logic [7:0] TmoLast = 8'(TMO - 1);

    logic        rply_s;
    logic [15:0] ad_s;

    qbus_sync2 #(.Width(1)) u_sync_rply (
        .vm_clk_p (vm_clk_p),
        .vm_rst_n (vm_rst_n),
        .d_i      (qb_rply_i),
        .q_o      (rply_s)
    );

    qbus_sync2 #(.Width(16)) u_sync_ad (
        .vm_clk_p (vm_clk_p),
        .vm_rst_n (vm_rst_n),
        .d_i      (qb_ad_i),
        .q_o      (ad_s)
    );

    qb_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] ad_q, ad_d, wdat_q, wdat_d, rdat_q, rdat_d, vec_q, vec_d;
    logic        ad_oe_q, ad_oe_d, sync_q, sync_d, din_q, din_d, dout_q, dout_d;
    logic        wtbt_q, wtbt_d, bs7_q, bs7_d, iako_q, iako_d;
    logic        ack_q, ack_d, err_q, err_d, iack_ack_q, iack_ack_d;
    logic        we_q, we_d, byte_q, byte_d, is_data_q, is_data_d, cyc_ok_q, cyc_ok_d;
    logic        timeout;
    logic        idle_free;
    logic [15:0] req_adr;
    logic        unused_adr0;

    assign unused_adr0 = wbs_adr_i[0];
    assign req_adr     = {wbs_adr_i[15:1], wbs_sel_i == 2'b10};
    // Hold off while a completion pulse is still visible so the master can drop stb.
    assign idle_free   = !(ack_q || err_q || iack_ack_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ad_d       = ad_q;
        ad_oe_d    = ad_oe_q;
        sync_d     = sync_q;
        din_d      = din_q;
        dout_d     = dout_q;
        wtbt_d     = wtbt_q;
        bs7_d      = bs7_q;
        iako_d     = iako_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        iack_ack_d = 1'b0;
        rdat_d     = rdat_q;
        vec_d      = vec_q;
        wdat_d     = wdat_q;
        we_d       = we_q;
        byte_d     = byte_q;
        is_data_d  = is_data_q;
        cyc_ok_d   = cyc_ok_q & wbs_cyc_i;
        timeout    = 1'b0;

        case (state_q)
            StIdle: begin
                if (idle_free && wbs_cyc_i && wbs_stb_i) begin
                    state_d   = StAddr;
                    cnt_d     = '0;
                    ad_d      = req_adr;
                    ad_oe_d   = 1'b1;
                    wtbt_d    = wbs_we_i;
                    bs7_d     = is_bs7(req_adr);
                    wdat_d    = wbs_dat_i;
                    we_d      = wbs_we_i;
                    byte_d    = (wbs_sel_i != 2'b11);
                    is_data_d = 1'b1;
                    cyc_ok_d  = 1'b1;
                end else if (idle_free && wbi_stb_i) begin
                    state_d   = StIack;
                    cnt_d     = '0;
                    din_d     = 1'b1;
                    iako_d    = 1'b0;
                    is_data_d = 1'b0;
                end
            end
            StAddr: begin
                if (cnt_q == AsuLast) begin
                    state_d = StAsync;
                    cnt_d   = '0;
                    sync_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StAsync: begin
                if (cnt_q == AhdLast) begin
                    cnt_d = '0;
                    if (we_q) begin
                        state_d = StWdat;
                        ad_d    = wdat_q;
                        wtbt_d  = byte_q;
                    end else begin
                        state_d = StRdin;
                        ad_oe_d = 1'b0;
                        wtbt_d  = 1'b0;
                        din_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWdat: begin
                if (cnt_q == DsuLast) begin
                    state_d = StWdout;
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StRdin, StWdout: begin
                if (rply_s) begin
                    state_d = StNrply;
                    din_d   = 1'b0;
                    dout_d  = 1'b0;
                    if (state_q == StRdin) rdat_d = ad_s;
                end else if (cnt_q == TmoLast) begin
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StIack: begin
                if (!iako_q) begin
                    if (cnt_q == AsuLast) begin
                        iako_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (rply_s) begin
                    state_d = StNrply;
                    vec_d   = ad_s;
                    din_d   = 1'b0;
                    iako_d  = 1'b0;
                end else if (cnt_q == TmoLast) begin
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StNrply: begin
                if (!rply_s) begin
                    state_d    = StDone;
                    sync_d     = 1'b0;
                    ad_oe_d    = 1'b0;
                    wtbt_d     = 1'b0;
                    bs7_d      = 1'b0;
                    ack_d      = is_data_q & cyc_ok_d;
                    iack_ack_d = !is_data_q;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (timeout) begin
            state_d    = StIdle;
            sync_d     = 1'b0;
            din_d      = 1'b0;
            dout_d     = 1'b0;
            iako_d     = 1'b0;
            ad_oe_d    = 1'b0;
            wtbt_d     = 1'b0;
            bs7_d      = 1'b0;
            err_d      = is_data_q & cyc_ok_d;
            iack_ack_d = !is_data_q;
            if (!is_data_q) vec_d = '0;
        end
    end

    always_ff @(posedge vm_clk_p) begin
        if (!vm_rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ad_q       <= '0;
            ad_oe_q    <= 1'b0;
            sync_q     <= 1'b0;
            din_q      <= 1'b0;
            dout_q     <= 1'b0;
            wtbt_q     <= 1'b0;
            bs7_q      <= 1'b0;
            iako_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            iack_ack_q <= 1'b0;
            rdat_q     <= '0;
            vec_q      <= '0;
            wdat_q     <= '0;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            is_data_q  <= 1'b0;
            cyc_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ad_q       <= ad_d;
            ad_oe_q    <= ad_oe_d;
            sync_q     <= sync_d;
            din_q      <= din_d;
            dout_q     <= dout_d;
            wtbt_q     <= wtbt_d;
            bs7_q      <= bs7_d;
            iako_q     <= iako_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            iack_ack_q <= iack_ack_d;
            rdat_q     <= rdat_d;
            vec_q      <= vec_d;
            wdat_q     <= wdat_d;
            we_q       <= we_d;
            byte_q     <= byte_d;
            is_data_q  <= is_data_d;
            cyc_ok_q   <= cyc_ok_d;
        end
    end

    assign wbs_dat_o = rdat_q;
    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;
    assign wbi_dat_o = vec_q;
    assign wbi_ack_o = iack_ack_q;
    assign qb_ad_o   = ad_q;
    assign qb_ad_oe  = ad_oe_q;
    assign qb_sync_o = sync_q;
    assign qb_din_o  = din_q;
    assign qb_dout_o = dout_q;
    assign qb_wtbt_o = wtbt_q;
    assign qb_bs7_o  = bs7_q;
    assign qb_iako_o = iako_q;

endmodule

// File: tb/tb_vm2_qbus_master.sv
// Directed bench for vm2_qbus_master with a simple Q-bus slave model answering DIN/DOUT/IAKO.
module tb_vm2_qbus_master;

    logic        vm_clk_p = 1'b0;
    logic        vm_rst_n = 1'b0;
    logic [15:0] wbs_adr_i = '0;
    logic [15:0] wbs_dat_i = '0;
    logic [15:0] wbs_dat_o;
    logic [1:0]  wbs_sel_i = '0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic        wbs_ack_o, wbs_err_o;
    logic        wbi_stb_i = 1'b0;
    logic [15:0] wbi_dat_o;
    logic        wbi_ack_o;
    logic [15:0] qb_ad_o;
    logic        qb_ad_oe;
    logic [15:0] qb_ad_i = '0;
    logic        qb_sync_o, qb_din_o, qb_dout_o, qb_wtbt_o, qb_bs7_o, qb_iako_o;
    logic        qb_rply_i = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 vm_clk_p = ~vm_clk_p;

    vm2_qbus_master #(
        .T_ASU (2),
        .T_AHD (2),
        .T_DSU (2),
        .TMO   (16)
    ) dut (
        .vm_clk_p  (vm_clk_p),
        .vm_rst_n  (vm_rst_n),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_sel_i (wbs_sel_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_err_o (wbs_err_o),
        .wbi_stb_i (wbi_stb_i),
        .wbi_dat_o (wbi_dat_o),
        .wbi_ack_o (wbi_ack_o),
        .qb_ad_o   (qb_ad_o),
        .qb_ad_oe  (qb_ad_oe),
        .qb_ad_i   (qb_ad_i),
        .qb_sync_o (qb_sync_o),
        .qb_din_o  (qb_din_o),
        .qb_dout_o (qb_dout_o),
        .qb_wtbt_o (qb_wtbt_o),
        .qb_bs7_o  (qb_bs7_o),
        .qb_iako_o (qb_iako_o),
        .qb_rply_i (qb_rply_i)
    );

    // Slave model: replies dev_delay cycles after DIN/DOUT, releases RPLY when the strobe drops.
    logic        dev_en = 1'b0;
    int          dev_delay = 5;
    logic [15:0] dev_data = '0;
    int          dev_cnt = 0;

    always @(negedge vm_clk_p) begin
        if (!dev_en || !(qb_din_o || qb_dout_o)) begin
            qb_rply_i = 1'b0;
            dev_cnt   = 0;
        end else if (dev_cnt >= dev_delay) begin
            qb_rply_i = 1'b1;
            qb_ad_i   = dev_data;
        end else begin
            dev_cnt++;
        end
    end

    int          ack_cnt, err_cnt, wbi_ack_cnt, din_cycles, din_pre_iako;
    logic        sync_seen, sync_prev;
    logic [15:0] addr_cap, wdat_cap;
    logic        bs7_cap, wtbt_a_cap, wtbt_d_cap, oe_cap;

    always @(negedge vm_clk_p) begin
        if (wbs_ack_o) ack_cnt++;
        if (wbs_err_o) err_cnt++;
        if (wbi_ack_o) wbi_ack_cnt++;
        if (qb_din_o) din_cycles++;
        if (qb_din_o && !qb_iako_o) din_pre_iako++;
        if (qb_sync_o) sync_seen = 1'b1;
        if (qb_sync_o && !sync_prev) begin
            addr_cap   = qb_ad_o;
            oe_cap     = qb_ad_oe;
            bs7_cap    = qb_bs7_o;
            wtbt_a_cap = qb_wtbt_o;
        end
        if (qb_dout_o) begin
            wtbt_d_cap = qb_wtbt_o;
            wdat_cap   = qb_ad_o;
        end
        sync_prev = qb_sync_o;
    end

    task automatic clear_mon();
        ack_cnt = 0; err_cnt = 0; wbi_ack_cnt = 0; din_cycles = 0; din_pre_iako = 0;
        sync_seen = 1'b0; addr_cap = 'x; wdat_cap = 'x; bs7_cap = 1'bx;
        wtbt_a_cap = 1'bx; wtbt_d_cap = 1'bx; oe_cap = 1'bx;
    endtask

    task automatic wb_xfer(input logic [15:0] adr, input logic [15:0] dat, input logic [1:0] sel,
                           input logic we, output logic got_ack, output logic got_err,
                           output logic [15:0] rdat);
        got_ack = 1'b0; got_err = 1'b0; rdat = 'x;
        @(posedge vm_clk_p); #1;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel; wbs_we_i = we;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge vm_clk_p); #1;
            if (wbs_ack_o || wbs_err_o) begin
                got_ack = wbs_ack_o; got_err = wbs_err_o; rdat = wbs_dat_o;
                break;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic test_reset();
        vm_rst_n = 1'b0;
        repeat (3) @(posedge vm_clk_p);
        #1;
        checks++;
        if ({qb_sync_o, qb_din_o, qb_dout_o, qb_wtbt_o, qb_bs7_o, qb_iako_o, qb_ad_oe,
             wbs_ack_o, wbs_err_o, wbi_ack_o} !== 10'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 0", {qb_sync_o, qb_din_o, qb_dout_o,
                     qb_wtbt_o, qb_bs7_o, qb_iako_o, qb_ad_oe, wbs_ack_o, wbs_err_o, wbi_ack_o});
        end
        checks++;
        if ({qb_ad_o, wbs_dat_o, wbi_dat_o} !== 48'b0) begin
            errors++;
            $display("FAIL reset_data: ad=%o dat=%o vec=%o want 0", qb_ad_o, wbs_dat_o, wbi_dat_o);
        end
        vm_rst_n = 1'b1;
    endtask

    task automatic test_read();
        logic a, e; logic [15:0] d;
        clear_mon();
        dev_en = 1'b1; dev_delay = 5; dev_data = 16'o123456;
        wb_xfer(16'o001000, 16'h0, 2'b11, 1'b0, a, e, d);
        checks++;
        if ({a, e} !== 2'b10) begin
            errors++; $display("FAIL read_ack: ack/err=%b want 10", {a, e});
        end
        checks++;
        if (d !== 16'o123456) begin
            errors++; $display("FAIL read_data: got %o want 123456", d);
        end
        checks++;
        if ({qb_sync_o, qb_rply_i} !== 2'b00) begin
            errors++; $display("FAIL read_sync_release: sync/rply=%b want 00", {qb_sync_o, qb_rply_i});
        end
        checks++;
        if ({addr_cap, bs7_cap, wtbt_a_cap, oe_cap} !== {16'o001000, 3'b001}) begin
            errors++;
            $display("FAIL read_addr_phase: adr=%o bs7=%b wtbt=%b oe=%b want 001000 0 0 1",
                     addr_cap, bs7_cap, wtbt_a_cap, oe_cap);
        end
        repeat (4) @(posedge vm_clk_p);
        #1;
        checks++;
        if (ack_cnt !== 1 || err_cnt !== 0) begin
            errors++; $display("FAIL read_single_ack: acks=%0d errs=%0d want 1 0", ack_cnt, err_cnt);
        end
    endtask

    task automatic test_byte_write();
        logic a, e; logic [15:0] d;
        clear_mon();
        dev_en = 1'b1; dev_delay = 3;
        wb_xfer(16'o177562, 16'o000101, 2'b10, 1'b1, a, e, d);
        repeat (4) @(posedge vm_clk_p);
        #1;
        checks++;
        if ({a, e} !== 2'b10 || ack_cnt !== 1) begin
            errors++; $display("FAIL bw_ack: ack/err=%b acks=%0d want 10 1", {a, e}, ack_cnt);
        end
        checks++;
        if (addr_cap !== 16'o177563 || bs7_cap !== 1'b1) begin
            errors++; $display("FAIL bw_addr: adr=%o bs7=%b want 177563 1", addr_cap, bs7_cap);
        end
        checks++;
        if ({wtbt_a_cap, wtbt_d_cap} !== 2'b11) begin
            errors++; $display("FAIL bw_wtbt: addr/data wtbt=%b want 11", {wtbt_a_cap, wtbt_d_cap});
        end
        checks++;
        if (wdat_cap !== 16'o000101) begin
            errors++; $display("FAIL bw_data: got %o want 000101", wdat_cap);
        end
    endtask

    task automatic test_timeout();
        logic a, e; logic [15:0] d;
        clear_mon();
        dev_en = 1'b0;
        wb_xfer(16'o002000, 16'h0, 2'b11, 1'b0, a, e, d);
        checks++;
        if ({a, e} !== 2'b01) begin
            errors++; $display("FAIL tmo_err: ack/err=%b want 01", {a, e});
        end
        checks++;
        if ({qb_sync_o, qb_din_o, qb_dout_o, qb_ad_oe, qb_wtbt_o} !== 5'b0) begin
            errors++;
            $display("FAIL tmo_strobes: got %b want 0",
                     {qb_sync_o, qb_din_o, qb_dout_o, qb_ad_oe, qb_wtbt_o});
        end
        checks++;
        if (din_cycles !== 16) begin
            errors++; $display("FAIL tmo_din_len: got %0d want 16", din_cycles);
        end
        repeat (4) @(posedge vm_clk_p);
        #1;
        checks++;
        if (err_cnt !== 1 || ack_cnt !== 0) begin
            errors++; $display("FAIL tmo_pulse: errs=%0d acks=%0d want 1 0", err_cnt, ack_cnt);
        end
        dev_en = 1'b1;
    endtask

    task automatic test_iack();
        logic got; logic [15:0] v;
        clear_mon();
        dev_en = 1'b1; dev_delay = 2; dev_data = 16'o000060;
        got = 1'b0; v = 'x;
        @(posedge vm_clk_p); #1;
        wbi_stb_i = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge vm_clk_p); #1;
            if (wbi_ack_o) begin
                got = 1'b1; v = wbi_dat_o;
                break;
            end
        end
        wbi_stb_i = 1'b0;
        repeat (4) @(posedge vm_clk_p);
        #1;
        checks++;
        if (got !== 1'b1 || v !== 16'o000060) begin
            errors++; $display("FAIL iack_vector: done=%b vec=%o want 1 000060", got, v);
        end
        checks++;
        if (sync_seen !== 1'b0) begin
            errors++; $display("FAIL iack_no_sync: sync_seen=%b want 0", sync_seen);
        end
        checks++;
        if (din_pre_iako !== 2) begin
            errors++; $display("FAIL iack_iako_delay: got %0d want 2", din_pre_iako);
        end
        checks++;
        if (wbi_ack_cnt !== 1 || ack_cnt !== 0) begin
            errors++;
            $display("FAIL iack_single_ack: wbi=%0d wbs=%0d want 1 0", wbi_ack_cnt, ack_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic d_done, v_done, d_first; logic [15:0] rd, vec;
        clear_mon();
        dev_en = 1'b1; dev_delay = 1; dev_data = 16'o111111;
        d_done = 1'b0; v_done = 1'b0; d_first = 1'b0; rd = 'x; vec = 'x;
        @(posedge vm_clk_p); #1;
        wbs_adr_i = 16'o000200; wbs_sel_i = 2'b11; wbs_we_i = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbi_stb_i = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(posedge vm_clk_p); #1;
            if (wbs_ack_o && !d_done) begin
                d_done = 1'b1; d_first = !v_done; rd = wbs_dat_o;
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
                dev_data = 16'o000100;
            end
            if (wbi_ack_o && !v_done) begin
                v_done = 1'b1; vec = wbi_dat_o;
                wbi_stb_i = 1'b0;
            end
            if (d_done && v_done) break;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbi_stb_i = 1'b0;
        checks++;
        if ({d_done, v_done, d_first} !== 3'b111) begin
            errors++;
            $display("FAIL b2b_order: data/vec/data_first=%b want 111", {d_done, v_done, d_first});
        end
        checks++;
        if (rd !== 16'o111111 || vec !== 16'o000100) begin
            errors++; $display("FAIL b2b_values: rd=%o vec=%o want 111111 000100", rd, vec);
        end
    endtask

    task automatic test_reset_mid();
        logic seen, a, e; logic [15:0] d;
        dev_en = 1'b1; dev_delay = 20;
        seen = 1'b0;
        @(posedge vm_clk_p); #1;
        wbs_adr_i = 16'o000400; wbs_dat_i = 16'o007777; wbs_sel_i = 2'b11; wbs_we_i = 1'b1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge vm_clk_p); #1;
            if (qb_dout_o) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++; $display("FAIL rst_mid_dout: dout seen=%b want 1", seen);
        end
        vm_rst_n = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge vm_clk_p); #1;
        checks++;
        if ({qb_sync_o, qb_din_o, qb_dout_o, qb_wtbt_o, qb_bs7_o, qb_iako_o, qb_ad_oe,
             wbs_ack_o, wbs_err_o, qb_ad_o} !== 26'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b/%o want 0", {qb_sync_o, qb_din_o, qb_dout_o,
                     qb_wtbt_o, qb_bs7_o, qb_iako_o, qb_ad_oe, wbs_ack_o, wbs_err_o}, qb_ad_o);
        end
        vm_rst_n = 1'b1;
        clear_mon();
        repeat (5) @(posedge vm_clk_p);
        #1;
        checks++;
        if (ack_cnt !== 0 || err_cnt !== 0) begin
            errors++; $display("FAIL rst_mid_no_ack: acks=%0d errs=%0d want 0 0", ack_cnt, err_cnt);
        end
        dev_delay = 2; dev_data = 16'o054321;
        wb_xfer(16'o000500, 16'h0, 2'b11, 1'b0, a, e, d);
        checks++;
        if ({a, e} !== 2'b10 || d !== 16'o054321) begin
            errors++;
            $display("FAIL rst_mid_read: ack/err=%b data=%o want 10 054321", {a, e}, d);
        end
    endtask

    initial begin
        clear_mon();
        sync_prev = 1'b0;
        test_reset();
        test_read();
        test_byte_write();
        test_timeout();
        test_iack();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
